// File: rtl/systolic_mm_stream.sv
// systolic_mm_stream
//   Weight-stationary N x N systolic matrix-vector engine with a job-level
//   FSM (IDLE / LOAD_W / STREAM / DRAIN), input skew, PE grid and output
//   de-skew. Computes y[j] = sum_i x[i] * W[i][j], where row i of W is the
//   i-th accepted weight row. Results leave in acceptance order, exactly
//   2*N advancing cycles after the vector was accepted.
//
//   A single global stall (advance = !(out_valid && !out_ready)) freezes
//   every skew, PE, de-skew and valid register, so out_vec holds while
//   the consumer back-pressures.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   start, reuse_w, num_vec job start (IDLE only), reuse resident weights,
//                           number of vectors in the job
//   w_valid/w_ready, w_row  weight-row handshake, element j in slice j
//   d_valid/d_ready, d_vec  data-vector handshake, element i in slice i
//   out_valid/out_ready,    result handshake, element j in slice j
//   out_vec
//   busy                    high whenever the FSM is not in IDLE
//   done                    one-cycle pulse when the last result is taken
//
// Configuration
//   SYSTOLIC_SAT_EN  defined: results saturate to the signed OUT_W range;
//                    undefined: results wrap (low OUT_W bits).
module systolic_mm_stream #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int OUT_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  reuse_w,
  input  logic [CNT_W-1:0]      num_vec,
  input  logic                  w_valid,
  output logic                  w_ready,
  input  logic [N*DATA_W-1:0]   w_row,
  input  logic                  d_valid,
  output logic                  d_ready,
  input  logic [N*DATA_W-1:0]   d_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N*OUT_W-1:0]    out_vec,
  output logic                  busy,
  output logic                  done
);
  localparam int ACC_W = 2*DATA_W + $clog2(N);
  localparam int BIG_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam int RW    = $clog2(N);
  localparam int LAT   = 2*N;
  localparam int IF_W  = $clog2(LAT+1);

  typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          remain;
  logic [RW-1:0]             row_cnt;
  logic                      weights_loaded;
  logic [IF_W-1:0]           inflight;
  logic                      advance, w_take, d_take, o_take, row_last;
  logic [LAT-1:0]            vld_p;

  logic signed [DATA_W-1:0]  w_r   [N][N];
  logic signed [DATA_W-1:0]  x_in  [N];
  logic signed [DATA_W-1:0]  x_w   [N][N-1];
  logic signed [ACC_W-1:0]   ps_w  [N][N];
  logic signed [ACC_W-1:0]   col_out [N];

  // Full-precision product, sign-extended to the accumulator width.
  function automatic logic signed [ACC_W-1:0] mac_term(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic signed [2*DATA_W-1:0] p;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    return ACC_W'(p);
  endfunction

  // Narrow an accumulator to the output width (saturate or wrap).
  function automatic logic [OUT_W-1:0] to_out(input logic signed [ACC_W-1:0] a);
    logic signed [BIG_W-1:0] e;
    e = BIG_W'(a);
`ifdef SYSTOLIC_SAT_EN
    // Overflow when the bits above the output sign bit disagree with it.
    if (!(&e[BIG_W-1:OUT_W-1]) && (|e[BIG_W-1:OUT_W-1]))
      return e[BIG_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      return OUT_W'(e);
`else
    return OUT_W'(e);
`endif
  endfunction

  assign out_valid = vld_p[LAT-1];
  assign advance   = !(out_valid && !out_ready);
  assign w_take    = w_valid && w_ready;
  assign d_take    = d_valid && d_ready;
  assign o_take    = out_valid && out_ready;
  assign row_last  = (row_cnt == RW'(N-1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    w_ready   = 1'b0;
    d_ready   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (reuse_w && weights_loaded)
            state_nxt = (num_vec == '0) ? DRAIN : STREAM;
          else
            state_nxt = LOAD_W;
        end
      end
      LOAD_W: begin
        w_ready = 1'b1;
        if (w_valid && row_last)
          state_nxt = (remain == '0) ? DRAIN : STREAM;
      end
      STREAM: begin
        d_ready = advance;
        if (d_valid && advance && remain == CNT_W'(1))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        // Nothing in flight only happens for an empty job.
        if (inflight == '0) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (o_take && inflight == IF_W'(1)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      remain         <= '0;
      row_cnt        <= '0;
      weights_loaded <= 1'b0;
      inflight       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start)
        remain <= num_vec;
      else if (d_take)
        remain <= remain - CNT_W'(1);
      if (w_take) begin
        row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        if (row_last)
          weights_loaded <= 1'b1;
      end
      case ({d_take, o_take})
        2'b10:   inflight <= inflight + IF_W'(1);
        2'b01:   inflight <= inflight - IF_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          w_r[i][j] <= '0;
    end else if (w_take) begin
      for (int j = 0; j < N; j++)
        w_r[row_cnt][j] <= w_row[j*DATA_W +: DATA_W];
    end
  end

  // ---- stage: valid pipeline, one bit per vector slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        vld_p <= '0;
    else if (advance) vld_p <= {vld_p[LAT-2:0], d_take};
  end

  // ---- stage: input skew, row i delayed by i advances
  for (genvar i = 0; i < N; i++) begin : g_skew
    logic signed [DATA_W-1:0] sr [i+1];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int k = 0; k <= i; k++) sr[k] <= '0;
      end else if (advance) begin
        sr[0] <= d_vec[i*DATA_W +: DATA_W];
        for (int k = 1; k <= i; k++) sr[k] <= sr[k-1];
      end
    end
    assign x_in[i] = sr[i];
  end

  // ---- stage: PE grid, x flows right, partial sums flow down
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic signed [DATA_W-1:0] x_cur;
      logic signed [ACC_W-1:0]  ps_in, ps;
      if (j == 0) begin : g_xl
        assign x_cur = x_in[i];
      end else begin : g_xr
        assign x_cur = x_w[i][j-1];
      end
      if (i == 0) begin : g_pt
        assign ps_in = '0;
      end else begin : g_pd
        assign ps_in = ps_w[i-1][j];
      end
      always_ff @(posedge clk or posedge reset) begin
        if (reset)        ps <= '0;
        else if (advance) ps <= ps_in + mac_term(x_cur, w_r[i][j]);
      end
      assign ps_w[i][j] = ps;
      if (j < N-1) begin : g_xreg
        logic signed [DATA_W-1:0] xr;
        always_ff @(posedge clk or posedge reset) begin
          if (reset)        xr <= '0;
          else if (advance) xr <= x_cur;
        end
        assign x_w[i][j] = xr;
      end
    end
  end

  // ---- stage: output de-skew, column j delayed by N-1-j advances
  for (genvar j = 0; j < N; j++) begin : g_dsk
    if (j == N-1) begin : g_direct
      assign col_out[j] = ps_w[N-1][j];
    end else begin : g_dly
      localparam int D = N-1-j;
      logic signed [ACC_W-1:0] dr [D];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 0; k < D; k++) dr[k] <= '0;
        end else if (advance) begin
          dr[0] <= ps_w[N-1][j];
          for (int k = 1; k < D; k++) dr[k] <= dr[k-1];
        end
      end
      assign col_out[j] = dr[D-1];
    end
    assign out_vec[j*OUT_W +: OUT_W] = to_out(col_out[j]);
  end

endmodule

// File: tb/tb_systolic_mm_stream.sv
// Self-checking bench for systolic_mm_stream: randomized jobs checked
// against a matrix-vector reference model, plus directed identity,
// throughput, backpressure, reuse, empty-job, reset and overflow cases.
module tb_systolic_mm_stream;
  localparam int N = 4, DW = 16, OW = 32, CW = 16;

  logic clk = 1'b0;
  logic reset;
  logic start, reuse_w, w_valid, w_ready, d_valid, d_ready;
  logic out_valid, out_ready, busy, done;
  logic [CW-1:0]   num_vec;
  logic [N*DW-1:0] w_row, d_vec;
  logic [N*OW-1:0] out_vec;

  logic b_start, b_reuse_w, b_w_valid, b_w_ready, b_d_valid, b_d_ready;
  logic b_out_valid, b_out_ready, b_busy, b_done;
  logic [15:0] b_num_vec;
  logic [31:0] b_w_row, b_d_vec, b_out_vec;

  always #5 clk = ~clk;

  systolic_mm_stream #(.N(N), .DATA_W(DW), .OUT_W(OW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .reuse_w(reuse_w), .num_vec(num_vec),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .d_valid(d_valid), .d_ready(d_ready), .d_vec(d_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec),
    .busy(busy), .done(done));

  systolic_mm_stream #(.N(2), .DATA_W(16), .OUT_W(16), .CNT_W(16)) dut2 (
    .clk(clk), .reset(reset), .start(b_start), .reuse_w(b_reuse_w), .num_vec(b_num_vec),
    .w_valid(b_w_valid), .w_ready(b_w_ready), .w_row(b_w_row),
    .d_valid(b_d_valid), .d_ready(b_d_ready), .d_vec(b_d_vec),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_vec(b_out_vec),
    .busy(b_busy), .done(b_done));

  int n_cmp = 0, n_bad = 0;
  int wm [N][N];
  int xs [64][N];
  bit model_loaded = 1'b0;
  int j_acc0, j_accl, j_out0, j_outl, j_wr, j_ov;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Signed sum narrowed to ow bits: clamp when saturating, else wrap.
  function automatic logic [63:0] fit(input longint s, input int ow);
    longint hi, lo, r;
    hi = (longint'(1) <<< (ow-1)) - 1;
    lo = -hi - 1;
    r  = s;
`ifdef SYSTOLIC_SAT_EN
    if (s > hi) r = hi;
    else if (s < lo) r = lo;
`endif
    return r & ((longint'(1) <<< ow) - 1);
  endfunction

  function automatic logic [127:0] ref_y(input int v);
    logic [127:0] y;
    logic [63:0]  f;
    longint       s;
    y = '0;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) s += longint'(xs[v][i]) * longint'(wm[i][j]);
      f = fit(s, OW);
      y[j*OW +: OW] = f[OW-1:0];
    end
    return y;
  endfunction

  task automatic fill_rand_w();
    logic signed [15:0] r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin r = 16'($urandom); wm[i][j] = int'(r); end
  endtask

  task automatic fill_rand_x(input int nv);
    logic signed [15:0] r;
    for (int v = 0; v < nv; v++)
      for (int i = 0; i < N; i++) begin r = 16'($urandom); xs[v][i] = int'(r); end
  endtask

  // bp_mode: 0 always ready, 1 random, 2 hold off for 5 cycles at result index 2
  task automatic run_job(input bit reuse, input int nvec, input int bp_mode,
                         input bit gaps, input string name);
    int rows = 0, sent = 0, got = 0, cyc = 0, stall_left = 5;
    bit loads, done_seen = 1'b0, prev_hold = 1'b0;
    logic [N*OW-1:0] prev_vec = '0;
    logic [127:0] q [$];
    loads = !(reuse && model_loaded);
    j_acc0 = -1; j_accl = -1; j_out0 = -1; j_outl = -1; j_wr = 0; j_ov = 0;
    @(negedge clk);
    start = 1'b1; reuse_w = reuse; num_vec = CW'(nvec);
    @(negedge clk);
    start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      w_valid = loads && rows < N && (!gaps || ($urandom % 3 != 0));
      if (rows < N) for (int j = 0; j < N; j++) w_row[j*DW +: DW] = 16'(wm[rows][j]);
      d_valid = sent < nvec && (!gaps || ($urandom % 3 != 0));
      for (int i = 0; i < N; i++) d_vec[i*DW +: DW] = 16'(xs[sent][i]);
      case (bp_mode)
        1: out_ready = ($urandom % 4 != 0);
        2: begin
          out_ready = !(got == 2 && out_valid && stall_left > 0);
          if (!out_ready) stall_left--;
        end
        default: out_ready = 1'b1;
      endcase
      #1;
      if (w_ready) j_wr++;
      if (out_valid) j_ov++;
      if (prev_hold) begin
        chk({name, "_hold_vld"}, out_valid, 1);
        chk({name, "_hold_vec"}, out_vec, prev_vec);
      end
      if (out_valid && !out_ready) chk({name, "_stall_dready"}, d_ready, 0);
      if (w_valid && w_ready) begin
        rows++;
        if (rows == N) model_loaded = 1'b1;
      end
      if (d_valid && d_ready) begin
        q.push_back(ref_y(sent));
        if (sent == 0) j_acc0 = cyc;
        j_accl = cyc;
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk({name, "_spurious"}, 1, 0);
        else chk({name, "_y"}, out_vec, q.pop_front());
        got++;
        if (j_out0 < 0) j_out0 = cyc;
        j_outl = cyc;
      end
      if (done) begin
        done_seen = 1'b1;
        chk({name, "_done_on_last"}, got, nvec);
      end
      prev_hold = out_valid && !out_ready;
      prev_vec  = out_vec;
      cyc++;
      @(negedge clk);
    end
    chk({name, "_done_seen"}, done_seen, 1);
    w_valid = 1'b0; d_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({name, "_idle_busy"}, busy, 0);
    chk({name, "_all_out"}, q.size(), 0);
  endtask

  initial begin
    int seen, t;
    logic [63:0] f;
    reset = 1'b1;
    start = 0; reuse_w = 0; num_vec = '0; w_valid = 0; w_row = '0;
    d_valid = 0; d_vec = '0; out_ready = 1'b1;
    b_start = 0; b_reuse_w = 0; b_num_vec = '0; b_w_valid = 0; b_w_row = '0;
    b_d_valid = 0; b_d_vec = '0; b_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {w_ready, d_ready, out_valid, busy, done}, 0);
    chk("rst_vec", out_vec, 0);
    @(negedge clk);
    reset = 1'b0;

    // Identity weights, single vector: latency and value.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = (i == j) ? 1 : 0;
    for (int i = 0; i < N; i++) xs[0][i] = i + 1;
    run_job(0, 1, 0, 0, "ident");
    chk("ident_latency", j_out0 - j_acc0, 2*N);
    chk("ident_value", ref_y(0), 128'h00000004_00000003_00000002_00000001);

    // All-2 weights, ten vectors back to back.
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) wm[i][j] = 2;
    for (int k = 1; k <= 10; k++) for (int i = 0; i < N; i++) xs[k-1][i] = k;
    run_job(0, 10, 0, 0, "thru");
    chk("thru_in_span", j_accl - j_acc0, 9);
    chk("thru_out_span", j_outl - j_out0, 9);

    run_job(0, 10, 2, 0, "bp");
    chk("bp_out_span", j_outl - j_out0, 14);

    run_job(1, 10, 0, 0, "reuse");
    chk("reuse_no_wready", j_wr, 0);

    for (int r = 0; r < 6; r++) begin
      bit ru;
      int nv;
      ru = 1'($urandom);
      nv = $urandom_range(1, 12);
      if (!(ru && model_loaded)) fill_rand_w();
      fill_rand_x(nv);
      run_job(ru, nv, 1, 1, "rand");
    end

    fill_rand_w();
    run_job(0, 0, 0, 0, "zero_ld");
    chk("zero_ld_no_out", j_ov, 0);
    chk("zero_ld_wbeats", j_wr, N);
    run_job(1, 0, 0, 0, "zero_reuse");
    chk("zero_reuse_no_out", j_ov, 0);

    // Mid-job reset while results are flowing.
    fill_rand_x(20);
    @(negedge clk);
    start = 1'b1; reuse_w = 1'b0; num_vec = CW'(20);
    @(negedge clk);
    start = 1'b0;
    seen = 0; t = 0;
    while (!seen && t < 100) begin
      w_valid = 1'b1; d_valid = 1'b1; out_ready = 1'b1;
      #1;
      if (out_valid) seen = 1;
      else begin t++; @(negedge clk); end
    end
    chk("mid_out_seen", seen, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ctrl", {w_ready, d_ready, out_valid, busy, done}, 0);
    chk("mid_rst_vec", out_vec, 0);
    @(negedge clk);
    reset = 1'b0; w_valid = 1'b0; d_valid = 1'b0;
    model_loaded = 1'b0;
    fill_rand_w();
    fill_rand_x(2);
    run_job(1, 2, 0, 0, "post_rst");
    chk("post_rst_reload", j_wr > 0, 1);

    // Overflow on a 2x2, 16-bit-output instance, then reset while stalled.
    @(negedge clk);
    b_start = 1'b1; b_num_vec = 16'd1;
    @(negedge clk);
    b_start = 1'b0; b_w_valid = 1'b1; b_w_row = {16'h7fff, 16'h7fff};
    seen = 0; t = 0;
    while (seen < 2 && t < 20) begin
      #1; if (b_w_valid && b_w_ready) seen++;
      t++; @(negedge clk);
    end
    b_w_valid = 1'b0; b_d_valid = 1'b1; b_d_vec = {16'h7fff, 16'h7fff}; b_out_ready = 1'b0;
    seen = 0; t = 0;
    while (!seen && t < 20) begin
      #1; if (b_d_valid && b_d_ready) seen = 1;
      t++; @(negedge clk);
    end
    b_d_valid = 1'b0;
    t = 0;
    while (!b_out_valid && t < 20) begin t++; @(negedge clk); end
    #1;
    f = fit(longint'(2147352578), 16);
    chk("ovf_valid", b_out_valid, 1);
    chk("ovf_vec", b_out_vec, {f[15:0], f[15:0]});
    @(negedge clk);
    #1;
    chk("ovf_hold", b_out_vec, {f[15:0], f[15:0]});
    reset = 1'b1;
    #1;
    chk("ovf_rst", {b_out_valid, b_out_vec, b_busy, b_done}, 0);
    @(negedge clk);
    reset = 1'b0; b_out_ready = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
